// File: rtl/uart_tx_arb.sv
// uart_tx_arb -- two-source round-robin byte arbiter in front of a UART
// transmitter. A selected byte is registered onto tx_data. A one-cycle
// tx_trig pulse starts the transmitter. The arbiter then waits out one
// full frame, 10*(BAUD_END+1)+FRAME_GAP cycles, before it selects again.
//
// Parameters:
//   BAUD_END  - per-bit terminal count of the transmitter (bit = BAUD_END+1 cycles)
//   FRAME_GAP - extra idle guard cycles appended after each frame
//
// Ports:
//   sclk, s_rst_n          - clock (rising edge), async active-low reset
//   inN_valid/data/ready   - per-source byte handshake (N = 0, 1)
//   tx_trig                - one-cycle start pulse to the transmitter
//   tx_data                - byte being transmitted (held until next selection)
//   busy                   - high whenever the arbiter is not idle
//   grant_id               - source of the last byte issued
//
// Optional feature: define UART_TX_ARB_FIFO_EN to give each source a
// 4-entry FIFO. Without it there is no storage. In that case a source is
// accepted only in the cycle in which it is selected.
module uart_tx_arb #(
  parameter int unsigned BAUD_END  = 5207,
  parameter int unsigned FRAME_GAP = 2
) (
  input  logic       sclk,
  input  logic       s_rst_n,
  input  logic       in0_valid,
  input  logic [7:0] in0_data,
  output logic       in0_ready,
  input  logic       in1_valid,
  input  logic [7:0] in1_data,
  output logic       in1_ready,
  output logic       tx_trig,
  output logic [7:0] tx_data,
  output logic       busy,
  output logic       grant_id
);

  localparam int unsigned FRAME_CYCLES = 10 * (BAUD_END + 1) + FRAME_GAP;
  localparam int unsigned TW_MIN       = $clog2(FRAME_CYCLES);
  localparam int unsigned TW           = (TW_MIN > 16) ? TW_MIN : 16;
  localparam logic [TW-1:0] FRAME_LAST = TW'(FRAME_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_TRIG, S_WAIT} state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] timer, timer_nxt;
  logic          rr_ptr;

  logic [1:0] vld;
  logic [1:0] pend;
  logic [7:0] head [2];
  logic       sel_id;
  logic       sel_fire;
  logic [7:0] sel_byte;

  assign vld = {in1_valid, in0_valid};

  // Both pending: the preferred source wins. Otherwise the only pending source wins.
  assign sel_id   = (&pend) ? rr_ptr : pend[1];
  assign sel_fire = (state == S_IDLE) && (|pend);
  assign sel_byte = head[sel_id];

`ifdef UART_TX_ARB_FIFO_EN
  logic [7:0] din    [2];
  logic [7:0] mem    [2][4];
  logic [1:0] wr_ptr [2];
  logic [1:0] rd_ptr [2];
  logic [2:0] count  [2];
  logic [1:0] full, push, pop;

  assign din[0]  = in0_data;
  assign din[1]  = in1_data;
  assign full    = {count[1] == 3'd4, count[0] == 3'd4};
  assign pend    = {count[1] != 3'd0, count[0] != 3'd0};
  // Ready comes from the registered count only. A full FIFO therefore
  // refuses a write even in the cycle it is popped.
  assign push    = vld & ~full;
  assign pop     = {sel_fire & sel_id, sel_fire & ~sel_id};
  assign head[0] = mem[0][rd_ptr[0]];
  assign head[1] = mem[1][rd_ptr[1]];
  assign in0_ready = ~full[0];
  assign in1_ready = ~full[1];

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      for (int unsigned i = 0; i < 2; i++) begin
        wr_ptr[i[0]] <= '0;
        rd_ptr[i[0]] <= '0;
        count[i[0]]  <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (push[i[0]]) wr_ptr[i[0]] <= wr_ptr[i[0]] + 2'd1;
        if (pop[i[0]])  rd_ptr[i[0]] <= rd_ptr[i[0]] + 2'd1;
        case ({push[i[0]], pop[i[0]]})
          2'b10:   count[i[0]] <= count[i[0]] + 3'd1;
          2'b01:   count[i[0]] <= count[i[0]] - 3'd1;
          default: count[i[0]] <= count[i[0]];
        endcase
      end
    end
  end

  always_ff @(posedge sclk) begin
    for (int unsigned i = 0; i < 2; i++) begin
      if (push[i[0]]) mem[i[0]][wr_ptr[i[0]]] <= din[i[0]];
    end
  end
`else
  assign pend      = vld;
  assign head[0]   = in0_data;
  assign head[1]   = in1_data;
  assign in0_ready = sel_fire & ~sel_id;
  assign in1_ready = sel_fire &  sel_id;
`endif

  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    case (state)
      S_IDLE: if (sel_fire) state_nxt = S_TRIG;
      S_TRIG: begin
        state_nxt = S_WAIT;
        timer_nxt = '0;
      end
      S_WAIT: begin
        if (timer == FRAME_LAST) begin
          state_nxt = S_IDLE;
          timer_nxt = '0;
        end else begin
          timer_nxt = timer + 1'b1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        timer_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state    <= S_IDLE;
      timer    <= '0;
      rr_ptr   <= 1'b0;
      tx_data  <= '0;
      grant_id <= 1'b0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
      if (sel_fire) begin
        tx_data  <= sel_byte;
        grant_id <= sel_id;
        rr_ptr   <= ~sel_id;
      end
    end
  end

  assign tx_trig = (state == S_TRIG);
  assign busy    = (state != S_IDLE);

endmodule

// File: doc/uart_tx_arb.md
UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 The block SHALL have parameter BAUD_END, default 5207, meaning the per-bit terminal count of the downstream transmitter (bit period = BAUD_END+1 cycles).
REQ-002 The block SHALL have parameter FRAME_GAP, default 2, meaning extra idle guard cycles appended after each frame.
REQ-003 The block SHALL have port sclk, input, 1 bit: the single clock, all logic on its rising edge.
REQ-004 The block SHALL have port s_rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have ports in0_valid / in1_valid, inputs, 1 bit each: requester has a byte.
REQ-006 The block SHALL have ports in0_data / in1_data, inputs, 8 bits each: requester byte.
REQ-007 The block SHALL have ports in0_ready / in1_ready, outputs, 1 bit each: byte accepted when valid&ready are high at the same rising edge.
REQ-008 The block SHALL have port tx_trig, output, 1 bit: one-cycle start pulse to the transmitter.
REQ-009 The block SHALL have port tx_data, output, 8 bits: byte to transmit, registered.
REQ-010 The block SHALL have port busy, output, 1 bit: high when the FSM is not in IDLE.
REQ-011 The block SHALL have port grant_id, output, 1 bit: source of the last byte issued.

Function
REQ-012 The FSM SHALL have three states, IDLE, TRIG and WAIT, with these transitions:
- IDLE->TRIG when a byte is selected.
- TRIG->WAIT after 1 cycle.
- WAIT->IDLE after exactly FRAME_CYCLES cycles, where FRAME_CYCLES = 10*(BAUD_END+1)+FRAME_GAP.
REQ-013 Frame-timer arithmetic SHALL use a counter of at least 16 bits, and the counter SHALL never wrap during WAIT.
REQ-014 Round-robin selection SHALL apply in IDLE:
- A 1-bit pointer rr_ptr names the preferred source.
- If both sources are pending, rr_ptr wins.
- If one source is pending, it wins regardless of rr_ptr.
- After a grant to source k, rr_ptr SHALL become !k.
REQ-015 On a selection, tx_data and grant_id SHALL load at the selecting edge, and tx_trig SHALL be 1 for exactly the single TRIG cycle.
REQ-016 tx_data SHALL remain stable from TRIG until the next selection.
REQ-017 Under continuous load, successive tx_trig pulses SHALL be spaced exactly FRAME_CYCLES+2 cycles apart.
REQ-018 A selection, and hence any handshake, SHALL be impossible while in TRIG or WAIT.
REQ-019 The block SHALL never accept more than one byte per source per cycle, and SHALL never drop or duplicate a byte.
REQ-020 Deasserting valid before the handshake SHALL be legal; that source is then simply not pending.

Reset
REQ-021 While s_rst_n is low, the block SHALL hold these values:
- FSM = IDLE, timer = 0, rr_ptr = 0.
- tx_trig = 0, tx_data = 8'h00, busy = 0, grant_id = 0.
- Both FIFOs empty when present.
REQ-022 Reset asserted mid-frame SHALL abort immediately with no further tx_trig, and pending FIFO contents SHALL be discarded.
REQ-023 The first selection after reset release SHALL occur no earlier than the first rising edge with s_rst_n high.

Configuration
REQ-024 With macro UART_TX_ARB_FIFO_EN defined, each source SHALL have a 4-entry FIFO:
- inN_ready = !full; a write occurs on valid&ready in any FSM state.
- "Pending" means FIFO not empty; the IDLE selection pops the head.
- When a FIFO is full, ready is low and a simultaneous pop SHALL NOT admit a write that cycle.
- Pointers SHALL wrap modulo 4, with count range 0..4.
REQ-025 Without UART_TX_ARB_FIFO_EN, there SHALL be no storage:
- "Pending" means inN_valid.
- inN_ready SHALL be high only in IDLE and only for the source that would be selected that cycle (combinational).
- The accepted byte is the selected one.

Verification (sim: BAUD_END=56, FRAME_GAP=2, so FRAME_CYCLES=572)
REQ-026 Single byte: in0 sends 8'hA5 in IDLE -> tx_trig pulses 1 cycle later with tx_data=8'hA5 and grant_id=0; busy stays high for 573 cycles, then the block returns to IDLE.
REQ-027 Contention: in0 and in1 both valid continuously (0x11 / 0x22) from reset -> issue order is 0x11, 0x22, 0x11, ...; tx_trig spacing is 574 cycles.
REQ-028 Single requester: only in1 valid with 3 bytes (0x01, 0x02, 0x03) -> all three are issued in order with grant_id=1; rr_ptr does not starve the source.
REQ-029 Backpressure, without FIFO: in0_valid is held during WAIT -> in0_ready stays 0 until IDLE, and exactly one transfer occurs.
REQ-030 FIFO full, with FIFO: in0 offers 6 bytes back-to-back -> 5 are accepted (1 popped immediately, then 4 stored); in0_ready goes low; the 6th is accepted after the next pop; all 6 are issued in order.
REQ-031 Reset mid-WAIT: s_rst_n is pulsed low at cycle 300 of a frame -> outputs reach their reset values asynchronously, and no tx_trig occurs until a new handshake.
